// File: rtl/vga_vram_port_if.sv
// CPU-side VRAM access bus: chip select, direction, address, data and the
// active-low acknowledge returned by the port.
interface vga_vram_port_if #(
  parameter int unsigned ADDR_W = 24
) ();
  logic              cs_vgamem;
  logic              cpu_rw;
  logic [ADDR_W-1:0] cpu_vram_addr;
  logic [7:0]        cpu_d_bus;
  logic [7:0]        cpu_d_out;
  logic              cpu_ack;

  modport master (
    output cs_vgamem, cpu_rw, cpu_vram_addr, cpu_d_bus,
    input  cpu_d_out, cpu_ack
  );

  modport slave (
    input  cs_vgamem, cpu_rw, cpu_vram_addr, cpu_d_bus,
    output cpu_d_out, cpu_ack
  );
endinterface

// File: rtl/vga_vram_port.sv
// CPU VRAM access port. CPU writes are queued in a FIFO and drained onto the
// shared VRAM bus only while the raster is blanked; CPU reads wait for the
// queue to empty so they never overtake an earlier write.
module vga_vram_port #(
  parameter int unsigned FIFO_AW = 4,
  parameter int unsigned ADDR_W  = 24
) (
  input  logic                clk_main,
  input  logic                reset_in,
  vga_vram_port_if.slave      cpu,
  input  logic                raster_visible,
  output logic [ADDR_W-1:0]   vram_a_bus,
  inout  wire  [7:0]          vram_d_bus,
  output logic                vram_we_n,
  output logic                vram_oe_n,
  output logic [FIFO_AW:0]    fifo_level,
  output logic                fifo_full
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StWrSetup  = 3'd1;
  localparam logic [2:0] StWrStrobe = 3'd2;
  localparam logic [2:0] StRdAddr   = 3'd3;
  localparam logic [2:0] StRdCap    = 3'd4;

  localparam logic [FIFO_AW:0] One   = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW:0] DepthW = {1'b1, {FIFO_AW{1'b0}}};

  logic [2:0]          state_q, state_d;
  logic [FIFO_AW:0]    wr_ptr_q, rd_ptr_q, level_q, level_d;
  logic                full_q, ack_q, rd_pend_q;
  logic [7:0]          dout_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [ADDR_W+7:0]   mem_q [2**FIFO_AW];
  logic [ADDR_W+7:0]   head;
  logic                empty, wr_req, rd_req, push, pop, wr_own, rd_own;

  assign empty  = (level_q == '0);
  assign wr_req = !cpu.cs_vgamem && !cpu.cpu_rw && ack_q;
  assign rd_req = !cpu.cs_vgamem && cpu.cpu_rw && ack_q && !rd_pend_q;
  assign pop    = (state_q == StWrStrobe);
  // A pop on the same edge frees the slot, so a full queue still accepts.
  assign push   = wr_req && (!full_q || pop);
  assign head   = mem_q[rd_ptr_q[FIFO_AW-1:0]];

  // Next FSM state: reads only go once the queue is empty, writes only in blanking.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (rd_pend_q && empty && !raster_visible)  state_d = StRdAddr;
        else if (!empty && !raster_visible)         state_d = StWrSetup;
      end
      StWrSetup:  state_d = raster_visible ? StIdle : StWrStrobe;
      StWrStrobe: state_d = StIdle;
      StRdAddr:   state_d = StRdCap;
      StRdCap:    state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Next queue occupancy; push and pop together leave it unchanged.
  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + One;
    else if (pop && !push) level_d = level_q - One;
  end

  // FSM, queue pointers, occupancy flags, ack and read capture.
  always_ff @(posedge clk_main or posedge reset_in) begin
    if (reset_in) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      full_q    <= 1'b0;
      ack_q     <= 1'b1;
      rd_pend_q <= 1'b0;
      rd_addr_q <= '0;
      dout_q    <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      full_q  <= (level_d == DepthW);
      if (push) wr_ptr_q <= wr_ptr_q + One;
      if (pop)  rd_ptr_q <= rd_ptr_q + One;

      if (rd_req) begin
        rd_pend_q <= 1'b1;
        rd_addr_q <= cpu.cpu_vram_addr;
      end else if (state_q == StRdCap) begin
        rd_pend_q <= 1'b0;
      end

      if (state_q == StRdCap) dout_q <= vram_d_bus;

      // One transfer per select: ack stays low until the CPU deselects.
      if (push || state_q == StRdCap) ack_q <= 1'b0;
      else if (!ack_q && cpu.cs_vgamem) ack_q <= 1'b1;
    end
  end

  // Queue storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk_main) begin
    if (push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= {cpu.cpu_vram_addr, cpu.cpu_d_bus};
  end

  assign wr_own = (state_q == StWrSetup) || (state_q == StWrStrobe);
  assign rd_own = (state_q == StRdAddr) || (state_q == StRdCap);

  // Strobes decode straight from state so an async reset releases them at once.
  assign vram_we_n  = (state_q != StWrStrobe);
  assign vram_oe_n  = !rd_own;
  assign vram_a_bus = wr_own ? head[ADDR_W+7:8] :
                      rd_own ? rd_addr_q : {ADDR_W{1'bz}};
  assign vram_d_bus = wr_own ? head[7:0] : 8'bz;

  assign cpu.cpu_ack   = ack_q;
  assign cpu.cpu_d_out = dout_q;
  assign fifo_level    = level_q;
  assign fifo_full     = full_q;

endmodule

// File: tb/tb_vga_vram_port.sv
// Scoreboard bench for vga_vram_port: the driver queues the expected VRAM bus
// transactions; a negedge monitor models the VRAM and checks each strobe/read.
module tb_vga_vram_port;
  localparam int unsigned FIFO_AW = 4;
  localparam int unsigned ADDR_W  = 24;

  logic              clk_main = 1'b0;
  logic              reset_in;
  logic              raster_visible;
  wire  [ADDR_W-1:0] vram_a_bus;
  wire  [7:0]        vram_d_bus;
  logic              vram_we_n, vram_oe_n;
  logic [FIFO_AW:0]  fifo_level;
  logic              fifo_full;

  vga_vram_port_if #(.ADDR_W(ADDR_W)) cpu ();

  vga_vram_port #(.FIFO_AW(FIFO_AW), .ADDR_W(ADDR_W)) dut (
    .clk_main       (clk_main),
    .reset_in       (reset_in),
    .cpu            (cpu),
    .raster_visible (raster_visible),
    .vram_a_bus     (vram_a_bus),
    .vram_d_bus     (vram_d_bus),
    .vram_we_n      (vram_we_n),
    .vram_oe_n      (vram_oe_n),
    .fifo_level     (fifo_level),
    .fifo_full      (fifo_full)
  );

  always #5 clk_main = ~clk_main;

  // VRAM model (low address byte only), driven during output-enable.
  logic [7:0] vmem [256];
  assign vram_d_bus = !vram_oe_n ? vmem[vram_a_bus[7:0]] : 8'bz;

  typedef struct packed {
    logic              is_rd;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_strobe = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic rd, input logic [ADDR_W-1:0] a, input logic [7:0] d);
    exp_t e;
    e.is_rd = rd;
    e.addr  = a;
    e.data  = d;
    return e;
  endfunction

  // Monitor: every write strobe and every completed read pops one expectation.
  exp_t              mon_e;
  logic              prev_oe_low = 1'b0;
  logic [ADDR_W-1:0] rd_addr_seen;
  always @(negedge clk_main) begin
    if (reset_in) begin
      prev_oe_low = 1'b0;
    end else begin
      if (!vram_we_n) begin
        n_strobe++;
        vmem[vram_a_bus[7:0]] = vram_d_bus;
        if (exp_q.size() == 0) begin
          check("unexpected write strobe", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("strobe kind is write", {31'd0, mon_e.is_rd}, 32'd0);
          check("write addr", {8'd0, vram_a_bus}, {8'd0, mon_e.addr});
          check("write data", {24'd0, vram_d_bus}, {24'd0, mon_e.data});
        end
      end
      if (!vram_oe_n && !prev_oe_low) rd_addr_seen = vram_a_bus;
      if (prev_oe_low && vram_oe_n) begin
        if (exp_q.size() == 0) begin
          check("unexpected read", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("read kind is read", {31'd0, mon_e.is_rd}, 32'd1);
          check("read addr", {8'd0, rd_addr_seen}, {8'd0, mon_e.addr});
          check("read data", {24'd0, cpu.cpu_d_out}, {24'd0, mon_e.data});
          check("read ack low", {31'd0, cpu.cpu_ack}, 32'd0);
        end
      end
      prev_oe_low = !vram_oe_n;
    end
  end

  task automatic tick();
    @(posedge clk_main);
    #1;
  endtask

  task automatic wait_ack(input logic lvl, input int budget, input string name);
    int n = 0;
    while (cpu.cpu_ack !== lvl && n < budget) begin
      tick();
      n++;
    end
    check(name, {31'd0, cpu.cpu_ack}, {31'd0, lvl});
  endtask

  task automatic wait_empty(input int budget, input string name);
    int n = 0;
    while (fifo_level != '0 && n < budget) begin
      tick();
      n++;
    end
    check(name, {27'd0, fifo_level}, 32'd0);
  endtask

  // Full write handshake; expects the port to accept (queue not full).
  task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    cpu.cs_vgamem     = 1'b0;
    cpu.cpu_rw        = 1'b0;
    cpu.cpu_vram_addr = a;
    cpu.cpu_d_bus     = d;
    exp_q.push_back(mk(1'b0, a, d));
    tick();
    check("write ack same edge", {31'd0, cpu.cpu_ack}, 32'd0);
    cpu.cs_vgamem = 1'b1;
    tick();
    check("ack release", {31'd0, cpu.cpu_ack}, 32'd1);
  endtask

  int base;

  initial begin
    for (int i = 0; i < 256; i++) vmem[i] = 8'h00;
    reset_in          = 1'b1;
    raster_visible    = 1'b1;
    cpu.cs_vgamem     = 1'b1;
    cpu.cpu_rw        = 1'b0;
    cpu.cpu_vram_addr = '0;
    cpu.cpu_d_bus     = '0;
    tick();
    tick();
    check("rst cpu_ack", {31'd0, cpu.cpu_ack}, 32'd1);
    check("rst cpu_d_out", {24'd0, cpu.cpu_d_out}, 32'd0);
    check("rst we_n", {31'd0, vram_we_n}, 32'd1);
    check("rst oe_n", {31'd0, vram_oe_n}, 32'd1);
    check("rst level", {27'd0, fifo_level}, 32'd0);
    check("rst full", {31'd0, fifo_full}, 32'd0);
    reset_in = 1'b0;
    tick();

    // Single write held off by the visible raster, then drained.
    cpu_write(24'h000100, 8'h41);
    check("level after one write", {27'd0, fifo_level}, 32'd1);
    repeat (4) tick();
    check("no strobe while visible", n_strobe, 0);
    raster_visible = 1'b0;
    wait_empty(20, "drain single");
    check("one strobe", n_strobe, 1);

    // Seventeen writes into a sixteen-entry queue.
    raster_visible = 1'b1;
    tick();
    base = n_strobe;
    for (int i = 0; i < 16; i++) cpu_write(24'h000200 + 24'(i), 8'h10 + 8'(i));
    check("level full", {27'd0, fifo_level}, 32'd16);
    check("full flag", {31'd0, fifo_full}, 32'd1);
    cpu.cs_vgamem     = 1'b0;
    cpu.cpu_rw        = 1'b0;
    cpu.cpu_vram_addr = 24'h000210;
    cpu.cpu_d_bus     = 8'h20;
    exp_q.push_back(mk(1'b0, 24'h000210, 8'h20));
    repeat (3) tick();
    check("17th stalled", {31'd0, cpu.cpu_ack}, 32'd1);
    raster_visible = 1'b0;
    wait_ack(1'b0, 20, "17th acked");
    check("17th acked at first pop", n_strobe - base, 1);
    check("level stays 16 on push+pop", {27'd0, fifo_level}, 32'd16);
    cpu.cs_vgamem = 1'b1;
    tick();
    wait_empty(80, "drain 17");
    check("17 strobes", n_strobe - base, 17);

    // Read after three queued writes must not overtake them.
    raster_visible = 1'b1;
    base = n_strobe;
    cpu_write(24'd5, 8'hA0);
    cpu_write(24'd6, 8'hA1);
    cpu_write(24'd7, 8'hA2);
    cpu.cs_vgamem     = 1'b0;
    cpu.cpu_rw        = 1'b1;
    cpu.cpu_vram_addr = 24'd6;
    exp_q.push_back(mk(1'b1, 24'd6, 8'hA1));
    tick();
    raster_visible = 1'b0;
    wait_ack(1'b0, 40, "read ack");
    check("read value", {24'd0, cpu.cpu_d_out}, 32'h000000A1);
    check("writes before read", n_strobe - base, 3);
    cpu.cs_vgamem = 1'b1;
    cpu.cpu_rw    = 1'b0;
    tick();
    check("read ack release", {31'd0, cpu.cpu_ack}, 32'd1);

    // Raster goes visible while in WR_SETUP: aborted, retried later.
    raster_visible = 1'b1;
    tick();
    base = n_strobe;
    cpu_write(24'h000030, 8'h5A);
    raster_visible = 1'b0;
    tick();
    check("setup drives addr", {8'd0, vram_a_bus}, 32'h00000030);
    check("setup no strobe", {31'd0, vram_we_n}, 32'd1);
    raster_visible = 1'b1;
    repeat (5) tick();
    check("abort no strobe", n_strobe - base, 0);
    check("abort entry kept", {27'd0, fifo_level}, 32'd1);
    raster_visible = 1'b0;
    wait_empty(20, "drain after abort");
    check("retried strobe", n_strobe - base, 1);

    // Reset in the middle of a write strobe with four entries queued.
    raster_visible = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) cpu_write(24'h000040 + 24'(i), 8'hB0 + 8'(i));
    raster_visible = 1'b0;
    begin
      int n = 0;
      @(negedge clk_main);
      while (vram_we_n !== 1'b0 && n < 10) begin
        @(negedge clk_main);
        n++;
      end
    end
    check("strobe reached", {31'd0, vram_we_n}, 32'd0);
    #1 reset_in = 1'b1;
    #1;
    check("rst mid strobe we_n", {31'd0, vram_we_n}, 32'd1);
    check("rst mid strobe oe_n", {31'd0, vram_oe_n}, 32'd1);
    check("rst mid strobe level", {27'd0, fifo_level}, 32'd0);
    check("rst mid strobe ack", {31'd0, cpu.cpu_ack}, 32'd1);
    check("rst mid strobe d_out", {24'd0, cpu.cpu_d_out}, 32'd0);
    exp_q.delete();
    base = n_strobe;
    tick();
    reset_in = 1'b0;
    repeat (6) tick();
    check("no strobes after reset", n_strobe - base, 0);

    // Long select on one write: exactly one push.
    raster_visible = 1'b1;
    cpu.cs_vgamem     = 1'b0;
    cpu.cpu_rw        = 1'b0;
    cpu.cpu_vram_addr = 24'h000060;
    cpu.cpu_d_bus     = 8'h77;
    exp_q.push_back(mk(1'b0, 24'h000060, 8'h77));
    repeat (10) tick();
    check("long select one push", {27'd0, fifo_level}, 32'd1);
    check("long select ack low", {31'd0, cpu.cpu_ack}, 32'd0);
    cpu.cs_vgamem = 1'b1;
    tick();
    check("long select ack release", {31'd0, cpu.cpu_ack}, 32'd1);
    raster_visible = 1'b0;
    wait_empty(20, "drain long select");
    check("long select strobe", n_strobe - base, 1);

    repeat (2) tick();
    check("scoreboard empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
